// File: rtl/fifo_wr_arb.sv
// Write-domain controller for the asynchronous FIFO: round-robin arbitration of the
// single write port, binary/Gray write pointers and the registered full flag.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          arb_clk,
    input  logic                          arb_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [ADDR_WIDTH:0]           rptr_sync,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          mem_wen,
    output logic [ADDR_WIDTH-1:0]         mem_waddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [ADDR_WIDTH:0]           wptr_gray,
    output logic                          full
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = ADDR_WIDTH;

    logic [AW:0]      wbin;
    logic [AW:0]      wbin_next;
    logic [AW:0]      wgray_next;
    logic [AW:0]      rptr_full;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  win;
    logic             found;
    logic             grant_ok;

    // Round-robin search starting just after the last winner, wrapping upward.
    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        idx   = last;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Reset kills the write of the current cycle as well as the state.
    assign grant_ok  = found && !full && !arb_rst;
    assign mem_wen   = grant_ok;
    assign gnt_id    = grant_ok ? win : '0;
    assign mem_waddr = wbin[AW-1:0];

    always_comb begin
        gnt       = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_ok && (win == ID_W'(i))) begin
                gnt[i]    = 1'b1;
                mem_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wbin_next  = wbin + {{AW{1'b0}}, mem_wen};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign rptr_full  = {~rptr_sync[AW:AW-1], rptr_sync[AW-2:0]};

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            last      <= ID_W'(NUM_REQ - 1);
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            full      <= (wgray_next == rptr_full);
            if (mem_wen) begin
                last <= win;
            end
        end
    end

endmodule
